regfile_dump_reader: RTL and testbench

Sequential read-out engine for the 32 x 32-bit register file. On `start`, it walks an address range of the file through one combinational read port. It streams each word, tagged with its address, over a valid/ready interface at up to one word per cycle. It is the read-side counterpart of the register write path and is used for debug dumps and context save.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/dump_out_stage.sv | 47 ++++
 rtl/regfile_dump_reader.sv | 105 ++++++++++
 tb/tb_regfile_dump_reader.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the 32 x 32-bit register file and its dump reader.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = ADDR_W + 1;

  typedef enum logic {IDLE, RUN} dump_state_t;
endpackage

// File: rtl/dump_out_stage.sv
// Output holding register for the dump stream: load has priority over accept,
// contents stay put while stalled, and clear drops any pending word.
module dump_out_stage
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              last_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              last_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      addr_q  <= addr_i;
      last_q  <= last_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign addr_o  = addr_q;
  assign last_o  = last_q;
endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a (possibly wrapping) address range of the register file and streams
// each word with its index over valid/ready, one word per cycle when unstalled.
module regfile_dump_reader
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  span;
  logic              load, clr, last_word;

  // Subtraction is done at ADDR_W bits so a reversed range wraps through 31 -> 0.
  assign span = {1'b0, last_addr - first_addr} + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    load      = 1'b0;
    clr       = 1'b0;
    last_word = 1'b0;
    rd_addr   = (state_q == IDLE) ? first_addr : ptr_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          load      = 1'b1;
          last_word = (span == CNT_W'(1));
          rem_d     = span - CNT_W'(1);
          ptr_d     = first_addr + ADDR_W'(1);
          state_d   = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          clr     = 1'b1;
          rem_d   = '0;
          state_d = IDLE;
        end else begin
          if (rem_q != '0 && (!out_valid || out_ready)) begin
            load      = 1'b1;
            last_word = (rem_q == CNT_W'(1));
            rem_d     = rem_q - CNT_W'(1);
            ptr_d     = ptr_q + ADDR_W'(1);
          end
          // The final word can only be pending once rem_q is zero, so no load collides here.
          if (out_valid && out_ready && out_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  dump_out_stage u_out (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (load),
    .clr_i   (clr),
    .ready_i (out_ready),
    .data_i  (rd_data),
    .addr_i  (rd_addr),
    .last_i  (last_word),
    .valid_o (out_valid),
    .data_o  (out_data),
    .addr_o  (out_addr),
    .last_o  (out_last)
  );

  assign busy = (state_q == RUN);
  assign done = done_q;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: table of dump ranges plus hand-written abort/reset sequences.
module tb_regfile_dump_reader;
  logic        clk = 1'b0;
  logic        reset_n, start, abort, out_ready;
  logic [4:0]  first_addr, last_addr, rd_addr, out_addr;
  logic [31:0] rd_data, out_data;
  logic        out_valid, out_last, busy, done;
  logic [31:0] regs [0:31];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0] first;
    logic [4:0] last;
    int         exp_n;
    logic [7:0] stall;     // bit c set: out_ready low in cycle c after start
    int         exp_done;  // cycles after the start edge at which done is seen
    bit         wr;        // write DEADBEEF to R[20] early in the dump
  } vec_t;

  vec_t vecs [6];

  assign rd_data = regs[rd_addr];
  always #5 clk = ~clk;

  regfile_dump_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [4:0] a, input bit wr);
    if (wr && a == 5'd20) return 32'hDEADBEEF;
    return 32'hA5A50000 + {27'b0, a};
  endfunction

  // Called at a negedge; returns at the negedge where done is high.
  task automatic run_dump(input vec_t v, input string tag);
    int          acc    = 0;
    int          done_c = -1;
    logic [4:0]  exp_a  = v.first;
    logic        stalled = 1'b0;
    logic [31:0] hd = '0;
    logic [4:0]  ha = '0;
    logic        rdy;
    start = 1'b1; first_addr = v.first; last_addr = v.last; out_ready = 1'b0;
    for (int c = 0; c < 80 && done_c < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1 && v.wr) regs[20] = 32'hDEADBEEF;
      if (c == 0) begin
        check({tag, " valid after start"}, 32'(out_valid), 32'd1);
        check({tag, " busy after start"}, 32'(busy), 32'd1);
        check({tag, " done low after start"}, 32'(done), 32'd0);
      end
      if (stalled) begin
        check({tag, " held data"}, out_data, hd);
        check({tag, " held addr"}, 32'(out_addr), 32'(ha));
      end
      if (done) begin
        done_c = c;
      end else begin
        rdy = (c < 8) ? !v.stall[c[2:0]] : 1'b1;
        out_ready = rdy;
        stalled = out_valid && !rdy;
        hd = out_data;
        ha = out_addr;
        if (out_valid && rdy) begin
          check({tag, " addr"}, 32'(out_addr), 32'(exp_a));
          check({tag, " data"}, out_data, exp_word(exp_a, v.wr));
          check({tag, " last"}, 32'(out_last), 32'(acc == v.exp_n - 1));
          acc++;
          exp_a = exp_a + 5'd1;
        end
      end
    end
    check({tag, " word count"}, 32'(acc), 32'(v.exp_n));
    check({tag, " done cycle"}, 32'(done_c), 32'(v.exp_done));
    check({tag, " busy low at done"}, 32'(busy), 32'd0);
    check({tag, " valid low at done"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hA5A50000 + i;
    reset_n = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    first_addr = 5'd3; last_addr = 5'd0;
    #1 reset_n = 1'b0;
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset out_addr", 32'(out_addr), 32'd0);
    check("reset out_last", 32'(out_last), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("idle rd_addr", 32'(rd_addr), 32'd3);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    vecs[0] = '{first: 5'd0,  last: 5'd31, exp_n: 32, stall: 8'h00, exp_done: 32, wr: 1'b0};
    vecs[1] = '{first: 5'd30, last: 5'd1,  exp_n: 4,  stall: 8'h00, exp_done: 4,  wr: 1'b0};
    vecs[2] = '{first: 5'd4,  last: 5'd6,  exp_n: 3,  stall: 8'h06, exp_done: 5,  wr: 1'b0};
    vecs[3] = '{first: 5'd7,  last: 5'd7,  exp_n: 1,  stall: 8'h00, exp_done: 1,  wr: 1'b0};
    vecs[4] = '{first: 5'd9,  last: 5'd10, exp_n: 2,  stall: 8'h00, exp_done: 2,  wr: 1'b0};
    vecs[5] = '{first: 5'd16, last: 5'd23, exp_n: 8,  stall: 8'h00, exp_done: 8,  wr: 1'b1};
    // Each dump is started in the done cycle of the previous one.
    for (int i = 0; i < 6; i++) run_dump(vecs[i], $sformatf("vec%0d", i));
    regs[20] = 32'hA5A50014;

    // Abort after three accepted words, with an ignored start while busy.
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd7; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; first_addr = 5'd20; last_addr = 5'd25;
    @(negedge clk); start = 1'b0;
    check("abort pre addr", 32'(out_addr), 32'd2);
    check("abort pre busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("abort pre addr3", 32'(out_addr), 32'd3);
    abort = 1'b1; out_ready = 1'b0;
    @(negedge clk); abort = 1'b0;
    check("abort valid", 32'(out_valid), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort last", 32'(out_last), 32'd0);
    check("abort no done", 32'(done), 32'd0);
    @(negedge clk);
    check("abort no done later", 32'(done), 32'd0);
    check("abort stays idle", 32'(busy), 32'd0);

    // start and abort together in IDLE: nothing starts.
    start = 1'b1; abort = 1'b1; first_addr = 5'd5; last_addr = 5'd6;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start+abort busy", 32'(busy), 32'd0);
    check("start+abort valid", 32'(out_valid), 32'd0);

    // Asynchronous reset while stalled mid-dump.
    start = 1'b1; first_addr = 5'd4; last_addr = 5'd12; out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    check("rst pre valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("rst pre stalled addr", 32'(out_addr), 32'd4);
    #1 reset_n = 1'b0;
    #1;
    check("async rst valid", 32'(out_valid), 32'd0);
    check("async rst data", out_data, 32'd0);
    check("async rst addr", 32'(out_addr), 32'd0);
    check("async rst last", 32'(out_last), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("post rst valid", 32'(out_valid), 32'd0);
    check("post rst rd_addr", 32'(rd_addr), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
